// File: rtl/dram_cycle_sequencer.sv
// VG8020 main-RAM DRAM sequencer: turns synchronised Z80 bus strobes into
// registered nRAS / address-mux / nCAS / nWE timing, plus RAS-only refresh.
module dram_cycle_sequencer #(
  parameter int RAS_TO_MUX = 1,
  parameter int MUX_TO_CAS = 1,
  parameter int REF_MIN    = 2,
  parameter int PRECHARGE  = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic nmreqd,
  input  logic nrdd,
  input  logic nwrd,
  input  logic nrfshd,
  input  logic ram_sel,
  output logic nras,
  output logic mux,
  output logic ncas,
  output logic nwe,
  output logic busy
);

  localparam int MAX_A = (RAS_TO_MUX > MUX_TO_CAS) ? RAS_TO_MUX : MUX_TO_CAS;
  localparam int MAX_B = (REF_MIN > PRECHARGE) ? REF_MIN : PRECHARGE;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] RTM_LAST = CW'(RAS_TO_MUX - 1);
  localparam logic [CW-1:0] MTC_LAST = CW'(MUX_TO_CAS - 1);
  localparam logic [CW-1:0] REF_LAST = CW'(REF_MIN - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(PRECHARGE - 1);

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    COL,
    CAS,
    REFRESH,
    PRECHG
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          armed, armed_nx;
  logic          wr_cyc, wr_cyc_nx;
  logic          go_idle;
  logic          can_start;
  logic          nras_nx, mux_nx, ncas_nx, nwe_nx, busy_nx;

  assign can_start = armed && !nmreqd;

  // Next-state logic; the pin values are decoded from the next state so they
  // leave the flops on the same edge as the state change.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    wr_cyc_nx = wr_cyc;
    armed_nx  = nmreqd ? 1'b1 : armed;
    go_idle   = 1'b0;

    case (state)
      IDLE: go_idle = 1'b1;
      ROW: begin
        if (nmreqd) begin
          state_nx = PRECHG;
          cnt_nx   = '0;
        end else if (cnt == RTM_LAST) begin
          state_nx = COL;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      COL: begin
        if (nmreqd) begin
          state_nx = PRECHG;
          cnt_nx   = '0;
        end else if (cnt != MTC_LAST) begin
          cnt_nx = cnt + CW'(1);
        end else if (!nrdd) begin
          state_nx  = CAS;
          wr_cyc_nx = 1'b0;
        end else if (!nwrd) begin
          state_nx  = CAS;
          wr_cyc_nx = 1'b1;
        end
      end
      CAS: begin
        if (nmreqd) begin
          state_nx = PRECHG;
          cnt_nx   = '0;
        end
      end
      REFRESH: begin
        if (cnt != REF_LAST) begin
          cnt_nx = cnt + CW'(1);
        end else if (nmreqd) begin
          state_nx = PRECHG;
          cnt_nx   = '0;
        end
      end
      PRECHG: begin
        if (cnt == PRE_LAST) go_idle = 1'b1;
        else cnt_nx = cnt + CW'(1);
      end
      default: state_nx = IDLE;
    endcase

    // A request held over from precharge starts on the IDLE-entry edge itself.
    if (go_idle) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      if (can_start && !nrfshd) begin
        state_nx = REFRESH;
        armed_nx = 1'b0;
      end else if (can_start && ram_sel) begin
        state_nx = ROW;
        armed_nx = 1'b0;
      end
    end

    nras_nx = !(state_nx inside {ROW, COL, CAS, REFRESH});
    mux_nx  = state_nx inside {COL, CAS};
    ncas_nx = (state_nx != CAS);
    nwe_nx  = !((state_nx == CAS) && wr_cyc_nx);
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state  <= IDLE;
      cnt    <= '0;
      armed  <= 1'b1;
      wr_cyc <= 1'b0;
      nras   <= 1'b1;
      mux    <= 1'b0;
      ncas   <= 1'b1;
      nwe    <= 1'b1;
      busy   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      armed  <= armed_nx;
      wr_cyc <= wr_cyc_nx;
      nras   <= nras_nx;
      mux    <= mux_nx;
      ncas   <= ncas_nx;
      nwe    <= nwe_nx;
      busy   <= busy_nx;
    end
  end

endmodule

// File: tb/tb_dram_cycle_sequencer.sv
// Directed bench for dram_cycle_sequencer; expected pin vectors are written
// as {nras, mux, ncas, nwe, busy} and derived by hand from the timing rules.
module tb_dram_cycle_sequencer;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic nmreqd = 1'b1, nrdd = 1'b1, nwrd = 1'b1, nrfshd = 1'b1, ram_sel = 1'b0;
  logic nras, mux, ncas, nwe, busy;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [4:0] P_IDLE = 5'b10110;
  localparam logic [4:0] P_ROW  = 5'b00111;
  localparam logic [4:0] P_COL  = 5'b01111;
  localparam logic [4:0] P_RD   = 5'b01011;
  localparam logic [4:0] P_WR   = 5'b01001;
  localparam logic [4:0] P_REF  = 5'b00111;
  localparam logic [4:0] P_PRE  = 5'b10111;

  dram_cycle_sequencer dut (
    .clk     (clk),
    .nreset  (nreset),
    .nmreqd  (nmreqd),
    .nrdd    (nrdd),
    .nwrd    (nwrd),
    .nrfshd  (nrfshd),
    .ram_sel (ram_sel),
    .nras    (nras),
    .mux     (mux),
    .ncas    (ncas),
    .nwe     (nwe),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic mreq, input logic rd, input logic wr,
                               input logic rfsh, input logic sel);
    nmreqd  = mreq;
    nrdd    = rd;
    nwrd    = wr;
    nrfshd  = rfsh;
    ram_sel = sel;
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] observed,
                             input logic [4:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got {nras,mux,ncas,nwe,busy}=%b, want %b", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expectPins(input string tag, input logic [4:0] expected);
    checkOutput(tag, {nras, mux, ncas, nwe, busy}, expected);
  endtask

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      step();
      expectPins("reset_hold", P_IDLE);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    nreset = 1'b1;
    step();
    expectPins("reset_release0", P_IDLE);
    step();
    expectPins("reset_release1", P_IDLE);

    // Read cycle
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(); expectPins("rd_e0", P_ROW);
    step(); expectPins("rd_e1", P_COL);
    step(); expectPins("rd_e2", P_RD);
    step(); expectPins("rd_e3", P_RD);
    step(); expectPins("rd_e4", P_RD);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(); expectPins("rd_e5", P_PRE);
    step(); expectPins("rd_e6", P_PRE);
    step(); expectPins("rd_e7", P_IDLE);

    // Write cycle with a late write strobe
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(); expectPins("wr_e0", P_ROW);
    step(); expectPins("wr_e1", P_COL);
    step(); expectPins("wr_e2", P_COL);
    step(); expectPins("wr_e3", P_COL);
    nwrd = 1'b0;
    step(); expectPins("wr_e4", P_WR);
    nwrd = 1'b1;
    step(); expectPins("wr_e5_strobe_up", P_WR);
    nmreqd = 1'b1;
    step(); expectPins("wr_e6", P_PRE);
    step(); expectPins("wr_e7", P_PRE);
    step(); expectPins("wr_e8", P_IDLE);

    // Refresh request for a single clock
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); expectPins("ref_e0", P_REF);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); expectPins("ref_e1", P_REF);
    step(); expectPins("ref_e2", P_PRE);
    step(); expectPins("ref_e3", P_PRE);
    step(); expectPins("ref_e4", P_IDLE);

    // Abort from ROW, then a request issued during precharge
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(); expectPins("ab_e0", P_ROW);
    nmreqd = 1'b1;
    step(); expectPins("ab_e1", P_PRE);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(); expectPins("ab_e2", P_PRE);
    step(); expectPins("b2b_e0", P_ROW);
    step(); expectPins("b2b_e1", P_COL);
    step(); expectPins("b2b_e2", P_RD);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); expectPins("b2b_end", P_PRE);
    step();
    step(); expectPins("b2b_idle", P_IDLE);

    // Memory cycle outside main RAM
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      expectPins("noram", P_IDLE);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); expectPins("noram_after", P_IDLE);

    // Asynchronous reset while in CAS
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(); step(); step();
    expectPins("async_cas", P_RD);
    #2 nreset = 1'b0;
    #1 expectPins("async_reset", P_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
